// File: rtl/mario_sprite_loader_pkg.sv
// Shared sprite geometry, frame numbering and loader state encoding for the
// Mario sprite memory (writer side and display-side frame selector).
package sprite_pkg;

    localparam int SPRITE_W    = 20;
    localparam int SPRITE_H    = 40;
    localparam int FRAME_SIZE  = SPRITE_W * SPRITE_H;
    localparam int NUM_FRAMES  = 3;
    localparam int FRAME_SEL_W = 2;

    localparam int X_W = $clog2(SPRITE_W);
    localparam int Y_W = $clog2(SPRITE_H);

    // Frame indices, identical on the display side so both agree on layout.
    localparam logic [FRAME_SEL_W-1:0] FRAME_STAND = 2'd0;
    localparam logic [FRAME_SEL_W-1:0] FRAME_RUN1  = 2'd1;
    localparam logic [FRAME_SEL_W-1:0] FRAME_RUN2  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    function automatic int frame_base(input logic [FRAME_SEL_W-1:0] sel);
        return int'(sel) * FRAME_SIZE;
    endfunction

endpackage

// File: rtl/mario_sprite_loader_if.sv
// Loader bus: control from the sprite source, pixel stream handshake and the
// sprite RAM write port. The loader is the slave; source/RAM side is master.
interface mario_sprite_loader_if
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
);

    logic                   start;
    logic [FRAME_SEL_W-1:0] frame_sel;
    logic                   abort;

    logic [DATA_W-1:0]      pix_data;
    logic                   pix_valid;
    logic                   pix_ready;

    logic [ADDR_W-1:0]      write_address_mario;
    logic [DATA_W-1:0]      write_data;
    logic                   write_en;

    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        output start, frame_sel, abort, pix_data, pix_valid,
        input  pix_ready, write_address_mario, write_data, write_en,
               busy, done, err
    );

    modport slave (
        input  start, frame_sel, abort, pix_data, pix_valid,
        output pix_ready, write_address_mario, write_data, write_en,
               busy, done, err
    );

endinterface

// File: rtl/mario_sprite_loader_counter.sv
// Raster x/y position within one sprite frame; x wraps at the row end and
// carries into y. last flags the bottom-right pixel.
module sprite_pixel_counter
    import sprite_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    logic x_wrap;

    assign x_wrap = (x == X_W'(SPRITE_W - 1));
    assign last   = x_wrap && (y == Y_W'(SPRITE_H - 1));

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would chain x into y within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_wrap) begin
                x <= '0;
                y <= last ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/mario_sprite_loader.sv
// Sprite RAM writer: loads one raster-order frame of palette indices into the
// region frame_sel*FRAME_SIZE, one registered RAM write per accepted pixel.
module mario_sprite_loader
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
) (
    input logic                  Clk,
    input logic                  Reset_n,
    mario_sprite_loader_if.slave bus
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] LOAD = ST_LOAD;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] base;

    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              last;

    logic              in_idle;
    logic              in_load;
    logic              frame_ok;
    logic              start_go;
    logic              start_bad;
    logic              accept;
    logic [ADDR_W-1:0] pix_addr;

    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_en_q;
    logic              done_q;
    logic              err_q;

    assign in_idle   = (state == IDLE);
    assign in_load   = (state == LOAD);
    assign frame_ok  = int'(bus.frame_sel) < NUM_FRAMES;
    assign start_go  = in_idle && bus.start && frame_ok;
    assign start_bad = in_idle && bus.start && !frame_ok;
    assign accept    = in_load && bus.pix_valid;

    // Full-width address arithmetic; the top frame ends at 3*FRAME_SIZE-1.
    assign pix_addr = base + ADDR_W'(y) * ADDR_W'(SPRITE_W) + ADDR_W'(x);

    sprite_pixel_counter u_counter (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .clear   (start_go),
        .advance (accept),
        .x       (x),
        .y       (y),
        .last    (last)
    );

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_go) state_nxt = LOAD;
            LOAD: begin
                if (bus.abort)           state_nxt = IDLE;
                else if (accept && last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            state <= state_nxt;
            if (start_go) base <= ADDR_W'(frame_base(bus.frame_sel));
        end
    end

    // A pixel accepted alongside abort is still written; only done is lost.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= accept;
            done_q  <= accept && last && !bus.abort;
            err_q   <= start_bad;
            if (accept) begin
                wr_addr_q <= pix_addr;
                wr_data_q <= bus.pix_data;
            end
        end
    end

    assign bus.pix_ready           = in_load;
    assign bus.busy                = in_load || (state == DONE);
    assign bus.write_address_mario = wr_addr_q;
    assign bus.write_data          = wr_data_q;
    assign bus.write_en            = wr_en_q;
    assign bus.done                = done_q;
    assign bus.err                 = err_q;

endmodule

// File: tb/tb_mario_sprite_loader.sv
// Directed bench for mario_sprite_loader: full-frame loads, bad frame select,
// valid gaps, abort and mid-load reset, with hand-computed expectations.
module tb_mario_sprite_loader;
    import sprite_pkg::*;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 4;

    logic Clk = 1'b0;
    logic Reset_n;

    int checks = 0;
    int errors = 0;

    mario_sprite_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mario_sprite_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // Write/pulse log, sampled on the falling edge away from the active edge.
    logic [ADDR_W-1:0] wr_addr[$];
    logic [DATA_W-1:0] wr_data[$];
    bit                wr_done[$];
    int                done_cnt = 0;
    int                err_cnt  = 0;

    always @(negedge Clk) begin
        if (bus.write_en === 1'b1) begin
            wr_addr.push_back(bus.write_address_mario);
            wr_data.push_back(bus.write_data);
            wr_done.push_back(bus.done === 1'b1);
        end
        if (bus.done === 1'b1) done_cnt++;
        if (bus.err === 1'b1)  err_cnt++;
    end

    int q0, d0, e0;

    task automatic mark();
        q0 = wr_addr.size();
        d0 = done_cnt;
        e0 = err_cnt;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.frame_sel = 2'd0;
        bus.abort     = 1'b0;
        bus.pix_data  = '0;
        bus.pix_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] fs);
        @(posedge Clk); #1;
        bus.start     = 1'b1;
        bus.frame_sel = fs;
        @(posedge Clk); #1;
        bus.start     = 1'b0;
        bus.frame_sel = 2'd0;
    endtask

    // Presents pixels first..first+n-1 on consecutive cycles, data = x[3:0].
    task automatic feed(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = DATA_W'(i % SPRITE_W);
            @(posedge Clk); #1;
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic abort_cleanup();
        bus.pix_valid = 1'b0;
        bus.abort     = 1'b1;
        @(posedge Clk); #1;
        bus.abort     = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle_inputs();
        #12;
        checks++;
        if ({bus.pix_ready, bus.busy, bus.write_en, bus.done, bus.err,
             bus.write_address_mario, bus.write_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b busy=%b wen=%b done=%b err=%b addr=%0d data=%0h expected all 0",
                     bus.pix_ready, bus.busy, bus.write_en, bus.done, bus.err,
                     bus.write_address_mario, bus.write_data);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if ({bus.pix_ready, bus.busy, bus.write_en, bus.done, bus.err} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got ready=%b busy=%b wen=%b done=%b err=%b expected all 0",
                     bus.pix_ready, bus.busy, bus.write_en, bus.done, bus.err);
        end
    endtask

    task automatic test_full_frame();
        int n, bad;
        mark();
        start_frame(2'd1);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 4'h0;
        @(negedge Clk);
        checks++;
        if (bus.pix_ready !== 1'b1 || bus.busy !== 1'b1 || bus.write_en !== 1'b0) begin
            errors++;
            $display("FAIL load_entry: got ready=%b busy=%b wen=%b expected 1 1 0",
                     bus.pix_ready, bus.busy, bus.write_en);
        end
        @(posedge Clk); #1;
        checks++;
        if (bus.write_en !== 1'b1 || bus.write_address_mario !== 19'd800) begin
            errors++;
            $display("FAIL first_write: got wen=%b addr=%0d expected 1 800",
                     bus.write_en, bus.write_address_mario);
        end
        feed(1, 799);
        repeat (3) @(posedge Clk);
        #1;
        n = wr_addr.size() - q0;
        checks++;
        if (n != 800) begin
            errors++;
            $display("FAIL frame1_count: got %0d expected 800", n);
        end else begin
            bad = 0;
            for (int i = 0; i < 800; i++)
                if (wr_addr[q0+i] !== ADDR_W'(800 + i) || wr_done[q0+i] !== (i == 799)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL frame1_sequence: got %0d bad writes expected 0", bad);
            end
            checks++;
            if (wr_addr[q0+19] !== 19'd819 || wr_addr[q0+20] !== 19'd820) begin
                errors++;
                $display("FAIL frame1_row_wrap: got %0d,%0d expected 819,820",
                         wr_addr[q0+19], wr_addr[q0+20]);
            end
            checks++;
            if (wr_addr[q0+799] !== 19'd1599 || wr_done[q0+799] !== 1'b1) begin
                errors++;
                $display("FAIL frame1_last: got addr=%0d done=%b expected 1599 1",
                         wr_addr[q0+799], wr_done[q0+799]);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL frame1_done_pulses: got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL frame1_idle: got busy=%b ready=%b expected 0 0", bus.busy, bus.pix_ready);
        end
    endtask

    task automatic test_data_pattern();
        int n, bad;
        mark();
        start_frame(2'd2);
        feed(0, 800);
        repeat (3) @(posedge Clk);
        #1;
        n = wr_addr.size() - q0;
        checks++;
        if (n != 800) begin
            errors++;
            $display("FAIL frame2_count: got %0d expected 800", n);
        end else begin
            bad = 0;
            for (int i = 0; i < 800; i++)
                if (wr_addr[q0+i] !== ADDR_W'(1600 + i) || wr_data[q0+i] !== DATA_W'(i % 20)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL frame2_sequence: got %0d bad writes expected 0", bad);
            end
            // x=19 -> 5'b10011, low nibble 4'h3; x=0 on the next row -> 4'h0.
            checks++;
            if (wr_addr[q0+19] !== 19'd1619 || wr_data[q0+19] !== 4'h3 ||
                wr_addr[q0+20] !== 19'd1620 || wr_data[q0+20] !== 4'h0) begin
                errors++;
                $display("FAIL frame2_row_wrap: got %0d:%0h %0d:%0h expected 1619:3 1620:0",
                         wr_addr[q0+19], wr_data[q0+19], wr_addr[q0+20], wr_data[q0+20]);
            end
            checks++;
            if (wr_addr[q0+799] !== 19'd2399) begin
                errors++;
                $display("FAIL frame2_last: got %0d expected 2399", wr_addr[q0+799]);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL frame2_done_pulses: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_bad_frame();
        mark();
        bus.pix_valid = 1'b1;
        @(posedge Clk); #1;
        bus.start     = 1'b1;
        bus.frame_sel = 2'd3;
        @(posedge Clk); #1;
        bus.start     = 1'b0;
        bus.frame_sel = 2'd0;
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL bad_frame_err: got err=%b busy=%b ready=%b expected 1 0 0",
                     bus.err, bus.busy, bus.pix_ready);
        end
        @(posedge Clk); #1;
        checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_frame_err_width: got err=%b busy=%b expected 0 0", bus.err, bus.busy);
        end
        repeat (2) @(posedge Clk);
        #1;
        bus.pix_valid = 1'b0;
        checks++;
        if (wr_addr.size() - q0 != 0 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL bad_frame_side_effects: got writes=%0d err_pulses=%0d expected 0 1",
                     wr_addr.size() - q0, err_cnt - e0);
        end
    endtask

    task automatic test_valid_gaps();
        bit                vld[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [DATA_W-1:0] dat[4] = '{4'hA, 4'h5, 4'h6, 4'hC};
        mark();
        start_frame(2'd0);
        for (int k = 0; k < 4; k++) begin
            bus.pix_valid = vld[k];
            bus.pix_data  = dat[k];
            bus.start     = (k == 1);
            bus.frame_sel = (k == 1) ? 2'd2 : 2'd0;
            @(posedge Clk); #1;
            checks++;
            if (bus.write_en !== vld[k] || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL gap_wen[%0d]: got wen=%b err=%b expected %b 0",
                         k, bus.write_en, bus.err, vld[k]);
            end
        end
        bus.start = 1'b0;
        abort_cleanup();
        checks++;
        if (wr_addr.size() - q0 != 2) begin
            errors++;
            $display("FAIL gap_count: got %0d expected 2", wr_addr.size() - q0);
        end else begin
            checks++;
            if (wr_addr[q0] !== 19'd0 || wr_addr[q0+1] !== 19'd1 ||
                wr_data[q0] !== 4'hA || wr_data[q0+1] !== 4'hC) begin
                errors++;
                $display("FAIL gap_writes: got %0d:%0h %0d:%0h expected 0:a 1:c",
                         wr_addr[q0], wr_data[q0], wr_addr[q0+1], wr_data[q0+1]);
            end
        end
        checks++;
        if (bus.busy !== 1'b0 || done_cnt != d0) begin
            errors++;
            $display("FAIL gap_abort_idle: got busy=%b done_pulses=%0d expected 0 0", bus.busy, done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int n, bad;
        mark();
        start_frame(2'd0);
        feed(0, 99);
        // The 100th pixel arrives together with abort and must still land.
        bus.pix_valid = 1'b1;
        bus.pix_data  = 4'h3;
        bus.abort     = 1'b1;
        @(posedge Clk); #1;
        bus.abort = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        bus.pix_valid = 1'b0;
        @(posedge Clk); #1;
        n = wr_addr.size() - q0;
        checks++;
        if (n != 100) begin
            errors++;
            $display("FAIL abort_count: got %0d expected 100", n);
        end else begin
            bad = 0;
            for (int i = 0; i < 100; i++)
                if (wr_addr[q0+i] !== ADDR_W'(i)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL abort_sequence: got %0d bad writes expected 0", bad);
            end
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.pix_ready !== 1'b0 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b ready=%b done_pulses=%0d expected 0 0 0",
                     bus.busy, bus.pix_ready, done_cnt - d0);
        end
        start_frame(2'd0);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 4'h7;
        @(posedge Clk); #1;
        bus.pix_valid = 1'b0;
        checks++;
        if (bus.write_en !== 1'b1 || bus.write_address_mario !== 19'd0) begin
            errors++;
            $display("FAIL abort_restart: got wen=%b addr=%0d expected 1 0",
                     bus.write_en, bus.write_address_mario);
        end
        abort_cleanup();
    endtask

    task automatic test_reset_mid_load();
        start_frame(2'd0);
        feed(0, 499);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 4'h3;
        @(posedge Clk); #2;
        checks++;
        if (bus.write_en !== 1'b1 || bus.write_address_mario !== 19'd499) begin
            errors++;
            $display("FAIL pre_reset_write: got wen=%b addr=%0d expected 1 499",
                     bus.write_en, bus.write_address_mario);
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.pix_ready, bus.busy, bus.write_en, bus.done, bus.err,
             bus.write_address_mario, bus.write_data} !== '0) begin
            errors++;
            $display("FAIL async_reset: got ready=%b busy=%b wen=%b done=%b err=%b addr=%0d data=%0h expected all 0",
                     bus.pix_ready, bus.busy, bus.write_en, bus.done, bus.err,
                     bus.write_address_mario, bus.write_data);
        end
        bus.pix_valid = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        mark();
        start_frame(2'd1);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 4'h9;
        @(posedge Clk); #1;
        bus.pix_valid = 1'b0;
        checks++;
        if (bus.write_en !== 1'b1 || bus.write_address_mario !== 19'd800 || bus.write_data !== 4'h9) begin
            errors++;
            $display("FAIL post_reset_start: got wen=%b addr=%0d data=%0h expected 1 800 9",
                     bus.write_en, bus.write_address_mario, bus.write_data);
        end
        abort_cleanup();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_data_pattern();
        test_bad_frame();
        test_valid_gaps();
        test_abort();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
